// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin channel arbiter and its select path.
package arb_pkg;

   typedef enum logic {SCAN = 1'b0, LOCK = 1'b1} arb_state_t;

   // ceil(log2 n), never below 1; valid for n up to 128
   function automatic int bit_length(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 8; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/multiplexer.sv
// N-to-1 word multiplexer; an out-of-range select yields zero.
module multiplexer
   import arb_pkg::*;
#(
   parameter int N = 5,
   parameter int M = 4,
   localparam int SEL_W = bit_length(N)
) (
   input  logic [N-1:0][M-1:0] i_channels,
   input  logic [SEL_W-1:0]    i_sel,
   output logic [M-1:0]        o_data
);

   always_comb begin
      o_data = '0;
      for (int i = 0; i < N; i++) begin
         if (i_sel == SEL_W'(i)) o_data = i_channels[i];
      end
   end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter with optional burst lock feeding one registered output word.
//
// state | meaning
// SCAN  | search from ptr for the first valid channel
// LOCK  | keep granting owner until BURST words or owner goes idle
module rr_channel_arbiter
   import arb_pkg::*;
#(
   parameter int N = 5,
   parameter int M = 4,
   parameter int BURST = 1,
   localparam int SEL_W = bit_length(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   input  logic [N-1:0][M-1:0]  in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [M-1:0]         out_data,
   output logic [SEL_W-1:0]     out_sel,
   input  logic                 out_ready
);

   localparam int CNT_W = $clog2(BURST + 1);

   arb_state_t       r_state, w_state_nxt;
   logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
   logic [SEL_W-1:0] r_owner, w_owner_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [SEL_W-1:0] w_grant;
   logic             w_load;
   logic [M-1:0]     w_mux_data;
   logic             r_out_valid;
   logic [M-1:0]     r_out_data;
   logic [SEL_W-1:0] r_out_sel;

   function automatic logic [SEL_W-1:0] inc_mod(input logic [SEL_W-1:0] x);
      return (x == SEL_W'(N - 1)) ? '0 : x + 1'b1;
   endfunction

   // first valid channel at or after start, wrapping at N
   function automatic logic [SEL_W-1:0] rr_search(input logic [N-1:0] v,
                                                  input logic [SEL_W-1:0] start);
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] g;
      logic             found;
      idx   = start;
      g     = start;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && v[idx]) begin
            g     = idx;
            found = 1'b1;
         end
         idx = inc_mod(idx);
      end
      return g;
   endfunction

   always_comb begin
      w_load      = (!r_out_valid || out_ready) && (|in_valid);
      w_grant     = '0;
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         SCAN: begin
            w_grant = rr_search(in_valid, r_ptr);
            if (w_load) begin
               w_cnt_nxt = CNT_W'(1);
               if (BURST == 1) begin
                  w_ptr_nxt = inc_mod(w_grant);
               end else begin
                  w_owner_nxt = w_grant;
                  w_state_nxt = LOCK;
               end
            end
         end
         LOCK: begin
            if (in_valid[r_owner]) begin
               w_grant = r_owner;
               if (w_load) begin
                  w_cnt_nxt = r_cnt + 1'b1;
                  if (int'(r_cnt) + 1 >= BURST) begin
                     w_ptr_nxt   = inc_mod(r_owner);
                     w_state_nxt = SCAN;
                  end
               end
            end else if (|in_valid) begin
               // owner went idle: hand over in the same cycle, no bubble
               w_grant = rr_search(in_valid, inc_mod(r_owner));
               if (w_load) begin
                  w_cnt_nxt   = CNT_W'(1);
                  w_owner_nxt = w_grant;
               end
            end else begin
               w_ptr_nxt   = inc_mod(r_owner);
               w_state_nxt = SCAN;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = w_load && !rst && (w_grant == SEL_W'(i));
      end
   end

   multiplexer #(.N(N), .M(M)) u_mux (
      .i_channels (in_data),
      .i_sel      (w_grant),
      .o_data     (w_mux_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SCAN;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_mux_data;
         r_out_sel   <= w_grant;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench: three arbiters (BURST 1, 2, 3) share stimulus; each test checks one of them.
module tb_rr_channel_arbiter;

   logic            clk;
   logic            rst;
   logic [4:0]      in_valid;
   logic [4:0][3:0] in_data;
   logic            out_ready;

   logic [2:0]      ov;
   logic [2:0][3:0] od;
   logic [2:0][2:0] os;
   logic [2:0][4:0] ir;

   int n_pass  = 0;
   int n_total = 0;

   rr_channel_arbiter #(.N(5), .M(4), .BURST(1)) u_b1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]), .out_ready(out_ready));

   rr_channel_arbiter #(.N(5), .M(4), .BURST(2)) u_b2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]), .out_ready(out_ready));

   rr_channel_arbiter #(.N(5), .M(4), .BURST(3)) u_b3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
      .out_valid(ov[2]), .out_data(od[2]), .out_sel(os[2]), .out_ready(out_ready));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      int         d;
      logic       r;
      logic [4:0] v;
      logic       rdy;
      logic [4:0] ir;
      logic       ov;
      logic [2:0] sel;
      logic [3:0] data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input int d, input logic r, input logic [4:0] v,
                      input logic rdy, input logic [4:0] e_ir, input logic e_ov,
                      input logic [2:0] e_sel, input logic [3:0] e_data);
      vecs.push_back('{name, d, r, v, rdy, e_ir, e_ov, e_sel, e_data});
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) in_data[i] = 4'(i + 3);

      // reset, BURST=1 rotation with wrap at 5, then backpressure
      add("rst_a",   0, 1, 5'b11111, 1, 5'b00000, 0, 0, 0);
      add("rst_b",   0, 1, 5'b11111, 1, 5'b00000, 0, 0, 0);
      add("rr0",     0, 0, 5'b11111, 1, 5'b00001, 1, 0, 3);
      add("rr1",     0, 0, 5'b11111, 1, 5'b00010, 1, 1, 4);
      add("rr2",     0, 0, 5'b11111, 1, 5'b00100, 1, 2, 5);
      add("rr3",     0, 0, 5'b11111, 1, 5'b01000, 1, 3, 6);
      add("rr4",     0, 0, 5'b11111, 1, 5'b10000, 1, 4, 7);
      add("rr_wrap", 0, 0, 5'b11111, 1, 5'b00001, 1, 0, 3);
      add("rr1b",    0, 0, 5'b11111, 1, 5'b00010, 1, 1, 4);
      add("rr2b",    0, 0, 5'b11111, 1, 5'b00100, 1, 2, 5);
      add("bp0",     0, 0, 5'b11111, 0, 5'b00000, 1, 2, 5);
      add("bp1",     0, 0, 5'b11111, 0, 5'b00000, 1, 2, 5);
      add("bp2",     0, 0, 5'b11111, 0, 5'b00000, 1, 2, 5);
      add("bp_rel",  0, 0, 5'b11111, 1, 5'b01000, 1, 3, 6);
      // BURST=2 with channels 2 and 3, then drain
      add("b2_rst",  1, 1, 5'b01100, 1, 5'b00000, 0, 0, 0);
      add("b2_a",    1, 0, 5'b01100, 1, 5'b00100, 1, 2, 5);
      add("b2_b",    1, 0, 5'b01100, 1, 5'b00100, 1, 2, 5);
      add("b2_c",    1, 0, 5'b01100, 1, 5'b01000, 1, 3, 6);
      add("b2_d",    1, 0, 5'b01100, 1, 5'b01000, 1, 3, 6);
      add("b2_e",    1, 0, 5'b01100, 1, 5'b00100, 1, 2, 5);
      add("b2_f",    1, 0, 5'b01100, 1, 5'b00100, 1, 2, 5);
      add("drain",   1, 0, 5'b00000, 1, 5'b00000, 0, 2, 5);
      // BURST=3 owner drops out, handover without bubble
      add("b3_rst",  2, 1, 5'b00010, 1, 5'b00000, 0, 0, 0);
      add("b3_g1",   2, 0, 5'b00010, 1, 5'b00010, 1, 1, 4);
      add("b3_hand", 2, 0, 5'b10000, 1, 5'b10000, 1, 4, 7);
      add("b3_idle", 2, 0, 5'b00000, 1, 5'b00000, 0, 4, 7);
      add("b3_ptr0", 2, 0, 5'b11111, 1, 5'b00001, 1, 0, 3);
      // BURST=3 reset in the middle of a lock
      add("b3r_rst", 2, 1, 5'b01000, 1, 5'b00000, 0, 0, 0);
      add("b3r_g3",  2, 0, 5'b01000, 1, 5'b01000, 1, 3, 6);
      add("b3r_mid", 2, 1, 5'b11111, 1, 5'b00000, 0, 0, 0);
      add("b3r_0a",  2, 0, 5'b11111, 1, 5'b00001, 1, 0, 3);
      add("b3r_0b",  2, 0, 5'b11111, 1, 5'b00001, 1, 0, 3);
      add("b3r_0c",  2, 0, 5'b11111, 1, 5'b00001, 1, 0, 3);
      add("b3r_1",   2, 0, 5'b11111, 1, 5'b00010, 1, 1, 4);

      for (int i = 0; i < vecs.size(); i++) begin
         rst       = vecs[i].r;
         in_valid  = vecs[i].v;
         out_ready = vecs[i].rdy;
         #1;
         chk({vecs[i].name, ".in_ready"}, int'(ir[vecs[i].d]), int'(vecs[i].ir));
         tick();
         chk({vecs[i].name, ".out_valid"}, int'(ov[vecs[i].d]), int'(vecs[i].ov));
         chk({vecs[i].name, ".out_sel"},   int'(os[vecs[i].d]), int'(vecs[i].sel));
         chk({vecs[i].name, ".out_data"},  int'(od[vecs[i].d]), int'(vecs[i].data));
      end

      // BURST=2 stalled mid-lock: burst count must survive the stall
      rst = 1'b1; in_valid = 5'b01100; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("lk_first.out_valid", int'(ov[1]), 1);
      chk("lk_first.out_sel", int'(os[1]), 2);
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("lk_stall.in_ready", int'(ir[1]), 0);
         tick();
         chk("lk_stall.out_sel", int'(os[1]), 2);
         chk("lk_stall.out_data", int'(od[1]), 5);
      end
      out_ready = 1'b1;
      #1;
      chk("lk_resume.in_ready", int'(ir[1]), 5'b00100);
      tick();
      chk("lk_resume.out_sel", int'(os[1]), 2);
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         tick();
         if (ov[1] && os[1] == 3'd3) found = 1'b1;
      end
      chk("lk_next_ch3_seen", int'(found), 1);
      chk("lk_next_ch3.out_data", int'(od[1]), 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rr_channel_arbiter.md
# rr_channel_arbiter

Round-robin arbiter that collects words from N independent producer channels of M bits and forwards one word per cycle into a single registered output stream. It sits directly upstream of the shared `multiplexer` data path. It computes the grant, drives the mux select, and registers the selected channel together with its index. An optional burst lock keeps a granted channel for up to BURST consecutive words before moving on.

## Interface
- N, 5: number of input channels, 1..128
- M, 4: bits per channel word
- BURST, 1: maximum consecutive grants to one channel, ≥1; 1 means pure round-robin
- SEL_W, derived: ceil(log2 N), minimum 1; not overridable
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  N  per-channel word available
- in_data  in  [N-1:0][M-1:0]  per-channel word
- in_ready  out  N  one-hot or zero; channel i's word is consumed on the cycle where in_valid[i] and in_ready[i] are both high
- out_valid  out  1  out_data and out_sel hold a word
- out_data  out  M  registered granted word
- out_sel  out  SEL_W  index of the channel that produced out_data
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high

## Operation
- Load enable: load = (!out_valid || out_ready) && (|in_valid). in_ready is combinational from load and grant, and carries no combinational path from in_data.
- Pointer ptr (SEL_W bits) marks the highest-priority channel. The search order is ptr, ptr+1, …, N-1, 0, …, ptr-1; the wrap is at N, not at 2^SEL_W.
- State machine, states SCAN and LOCK; registers owner (SEL_W bits) and cnt (counts up to BURST).
  - SCAN, load: grant g = first valid channel in search order, cnt←1. If BURST==1: ptr←(g+1) mod N and stay in SCAN. Otherwise: owner←g, go to LOCK.
  - LOCK, load, in_valid[owner]=1: grant owner, cnt←cnt+1. When cnt+1==BURST: ptr←(owner+1) mod N, go to SCAN.
  - LOCK, in_valid[owner]=0: in the same cycle, arbitrate as in SCAN with the search starting at (owner+1) mod N, so no bubble is inserted. If nothing is valid: ptr←(owner+1) mod N, go to SCAN.
  - No load (output stalled): state, ptr, owner and cnt hold; in_ready=0.
- On load: out_data←in_data[grant] via the multiplexer instance, out_sel←grant, out_valid←1.
- Output drained (out_valid && out_ready) with no load: out_valid←0; out_data and out_sel hold their last value.
- Widths: grant, ptr and owner are SEL_W bits; the increment is done mod N with an explicit compare against N-1.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, in_ready=0, ptr=0, state=SCAN, cnt=0, owner=0.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel are stable and in_ready is all zero.
- A simultaneous drain and load in the same cycle refills the output register; out_valid stays 1.
- rst mid-LOCK abandons the burst. The first grant after reset is the lowest-index valid channel.
- Only the output register is a pipeline stage. The request-to-grant path is purely combinational.

## Structure
- Shared package `arb_pkg`: function `bit_length(n)` returning ceil(log2 n) (minimum 1, n≤128), reused for SEL_W by all mux/select logic; typedef `arb_state_t` enum {SCAN, LOCK}.
- Sub-module: one `multiplexer #(.N(N), .M(M))` instance, with select=grant and channels=in_data, feeding the out_data register.
- Rotating priority search: a single combinational function in this module, no separate module.

## Test plan
All cases use N=5, M=4 unless stated.
1. Reset: rst=1 for 2 cycles with in_valid=5'b11111 → out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout; the first grant after release is channel 0.
2. BURST=1, all channels valid, out_ready=1, in_data[i]=i+3 → out_sel sequence 0,1,2,3,4,0 (wraps at 5, not 8); out_data is 3,4,5,6,7,3.
3. Backpressure: out_valid=1, out_sel=2, out_data=5; out_ready=0 for 3 cycles → outputs frozen, in_ready=0. out_ready=1 → the next grant is channel 3 with no lost word.
4. BURST=2, only channels 2 and 3 valid, out_ready=1 → out_sel 2,2,3,3,2,2.
5. BURST=3, channel 1 granted once, then in_valid[1] drops while channel 4 is valid → the next cycle grants channel 4 with no bubble; state returns to SCAN and ptr=0 after that grant.
6. BURST=3, rst asserted while in LOCK on channel 3 with cnt=1, all channels valid → after release: grant 0, 0, 0, then 1.
